rc4_decrypt: RTL and testbench

- RC4 keystream generation (PRGA) and decrypt stage. It runs after shuffle_arr has finished scheduling the S array.
- It reads and swaps bytes in s_memory, XORs each keystream byte with the encrypted message ROM, and writes plaintext to the decrypted-message RAM.
- The top-level FSM drives it through the same start/finish handshake as mem_init and shuffle_arr. The top muxes the s_memory port to this block while its state bit is set.

---
 rtl/rc4_decrypt.sv | 151 +++++++++++++++
 tb/tb_rc4_decrypt.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt.sv
// RC4 keystream (PRGA) and decrypt stage: swaps S bytes, XORs keystream with the ROM, writes plaintext RAM.
// Optional RC4_DECRYPT_CHECK_EN adds an 'invalid' output that stops on a non-lowercase/non-space byte.
module rc4_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              finish,
    output logic [7:0]        address,
    output logic [7:0]        data,
    output logic              wren,
    input  logic [7:0]        q,
    output logic [MSG_AW-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] dec_addr,
    output logic [7:0]        dec_data,
    output logic              dec_wren
`ifdef RC4_DECRYPT_CHECK_EN
    ,
    output logic              invalid
`endif
);

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] RD_I = 4'd1;
    localparam logic [3:0] WT_I = 4'd2;
    localparam logic [3:0] RD_J = 4'd3;
    localparam logic [3:0] WT_J = 4'd4;
    localparam logic [3:0] WR_I = 4'd5;
    localparam logic [3:0] WR_J = 4'd6;
    localparam logic [3:0] RD_F = 4'd7;
    localparam logic [3:0] WT_F = 4'd8;
    localparam logic [3:0] OUT  = 4'd9;
    localparam logic [3:0] DONE = 4'd10;

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    logic [3:0]        state;
    logic [7:0]        i, j, si, sj, f;
    logic [MSG_AW-1:0] k;
    logic [7:0]        plain;
    logic              last_byte;
    logic              stop_early;

    assign plain     = f ^ rom_q;
    assign last_byte = (k == K_LAST);
    assign rom_addr  = k;

`ifdef RC4_DECRYPT_CHECK_EN
    assign stop_early = !(((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20));
`else
    assign stop_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            si     <= '0;
            sj     <= '0;
            f      <= '0;
            finish <= 1'b0;
`ifdef RC4_DECRYPT_CHECK_EN
            invalid <= 1'b0;
`endif
        end else begin
            // finish lags DONE by one edge and drops together with the DONE->IDLE exit
            finish <= (state == DONE) && start;
            case (state)
                IDLE: begin
                    if (start) begin
                        i     <= 8'd1;
                        j     <= '0;
                        k     <= '0;
                        state <= RD_I;
`ifdef RC4_DECRYPT_CHECK_EN
                        invalid <= 1'b0;
`endif
                    end
                end
                RD_I: state <= WT_I;
                WT_I: begin
                    si    <= q;
                    j     <= j + q;
                    state <= RD_J;
                end
                RD_J: state <= WT_J;
                WT_J: begin
                    sj    <= q;
                    state <= WR_I;
                end
                WR_I: state <= WR_J;
                WR_J: state <= RD_F;
                RD_F: state <= WT_F;
                WT_F: begin
                    f     <= q;
                    state <= OUT;
                end
                OUT: begin
`ifdef RC4_DECRYPT_CHECK_EN
                    if (stop_early) invalid <= 1'b1;
`endif
                    if (last_byte || stop_early) begin
                        state <= DONE;
                    end else begin
                        k     <= k + 1'b1;
                        i     <= i + 8'd1;
                        state <= RD_I;
                    end
                end
                DONE: if (!start) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        address  = '0;
        data     = '0;
        wren     = 1'b0;
        dec_addr = '0;
        dec_data = '0;
        dec_wren = 1'b0;
        case (state)
            RD_I: address = i;
            RD_J: address = j;
            WR_I: begin
                address = i;
                data    = sj;
                wren    = 1'b1;
            end
            WR_J: begin
                address = j;
                data    = si;
                wren    = 1'b1;
            end
            RD_F: address = si + sj;
            OUT: begin
                dec_addr = k;
                dec_data = plain;
                dec_wren = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_decrypt.sv
// Directed self-checking bench for rc4_decrypt with behavioural S-memory, ROM and plaintext RAM.
// Define RC4_DECRYPT_CHECK_EN for both files to exercise the early-stop check instead of the full runs.
module tb_rc4_decrypt;

    logic       clk = 1'b0;
    logic       rst, start, finish, wren, dec_wren;
    logic [7:0] address, data, q, rom_q, dec_data;
    logic [4:0] rom_addr, dec_addr;
`ifdef RC4_DECRYPT_CHECK_EN
    logic       invalid;
`endif

    logic [7:0] smem [0:255];
    logic [7:0] rom  [0:31];
    logic [7:0] dmem [0:31];
    logic [7:0] exp_dec [0:31];
    logic [7:0] exp_s   [0:255];
    int         s_wr_cnt, dec_wr_cnt;
    logic [7:0] snap1, snap2, snap3, snap5;
    logic       k2_seen;
    int         n_cmp = 0;
    int         n_err = 0;

    rc4_decrypt #(.MSG_LEN(32), .MSG_AW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .address(address), .data(data), .wren(wren), .q(q),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .dec_addr(dec_addr), .dec_data(dec_data), .dec_wren(dec_wren)
`ifdef RC4_DECRYPT_CHECK_EN
        , .invalid(invalid)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        q     <= smem[address];
        rom_q <= rom[rom_addr];
        if (wren) begin
            smem[address] = data;
            s_wr_cnt++;
        end
        if (dec_wren) begin
            dmem[dec_addr] = dec_data;
            dec_wr_cnt++;
            if (dec_addr == 5'd0) snap1 = smem[1];
            if (dec_addr == 5'd2) begin
                snap2   = smem[2];
                snap3   = smem[3];
                snap5   = smem[5];
                k2_seen = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic prep(input logic [7:0] r0, input logic [7:0] r1);
        for (int x = 0; x < 256; x++) smem[x] = 8'(x);
        for (int x = 0; x < 32; x++) begin
            rom[x]  = 8'h00;
            dmem[x] = 8'hxx;
        end
        rom[0] = r0;
        rom[1] = r1;
        s_wr_cnt   = 0;
        dec_wr_cnt = 0;
        k2_seen    = 1'b0;
    endtask

    // Reference RC4 PRGA over an identity S array.
    task automatic model();
        logic [7:0] s [0:255];
        logic [7:0] mi, mj, t;
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        mi = 0;
        mj = 0;
        for (int n = 0; n < 32; n++) begin
            mi = mi + 8'd1;
            mj = mj + s[mi];
            t = s[mi]; s[mi] = s[mj]; s[mj] = t;
            exp_dec[n] = s[8'(s[mi] + s[mj])] ^ rom[n];
        end
        for (int x = 0; x < 256; x++) exp_s[x] = s[x];
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cycles = 0;
        while (cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (finish) break;
        end
    endtask

    task automatic check_full(input string tag);
        int bad;
        for (int n = 0; n < 32; n++) check({tag, "_dec"}, dmem[n], exp_dec[n]);
        bad = 0;
        for (int x = 0; x < 256; x++) if (smem[x] !== exp_s[x]) bad++;
        check({tag, "_s_mismatches"}, bad, 0);
    endtask

    initial begin
        int cyc, swc, dwc;
        rst   = 1'b1;
        start = 1'b0;
        prep(8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_finish", finish, 0);
        check("rst_wren", wren, 0);
        check("rst_dec_wren", dec_wren, 0);
        check("rst_address", address, 0);
        check("rst_data", data, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_dec_addr", dec_addr, 0);
        check("rst_dec_data", dec_data, 0);

`ifndef RC4_DECRYPT_CHECK_EN
        // Run 1: identity S, ROM zero
        pulse_reset();
        prep(8'h00, 8'h00);
        model();
        run(cyc);
        check("t1_latency", cyc, 289);
        check("t1_dec0", dmem[0], 8'h02);
        check("t1_dec1", dmem[1], 8'h05);
        check("t1_dec2", dmem[2], 8'h07);
        check("t1_i_eq_j_s1", snap1, 8'h01);
        check_full("t1");

        // Holding start keeps DONE with no writes
        swc = s_wr_cnt;
        dwc = dec_wr_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("hold_finish", finish, 1);
        check("hold_s_writes", s_wr_cnt, swc);
        check("hold_dec_writes", dec_wr_cnt, dwc);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("drop_finish", finish, 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_wren", wren, 0);
        check("idle_s_writes", s_wr_cnt, swc);

        // Run 2: restart from IDLE, ROM[0]=FF
        prep(8'hFF, 8'h00);
        model();
        run(cyc);
        check("t2_latency", cyc, 289);
        check("t2_dec0", dmem[0], 8'hFD);
        check("t2_s2", snap2, 8'h03);
        check("t2_s3", snap3, 8'h05);
        check("t2_s5", snap5, 8'h02);
        check_full("t2");

        // Reset during the third byte's WR_I
        pulse_reset();
        prep(8'h00, 8'h00);
        model();
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (cyc < 200 && !(dec_wr_cnt == 2 && wren)) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("abort_reached_wr_i", (dec_wr_cnt == 2 && wren), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wren", wren, 0);
        check("abort_dec_wren", dec_wren, 0);
        check("abort_finish", finish, 0);
        check("abort_address", address, 0);
        swc = s_wr_cnt;
        dwc = dec_wr_cnt;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_s_writes", s_wr_cnt, swc);
        check("abort_dec_writes", dec_wr_cnt, 2);
        rst = 1'b0;
        prep(8'h00, 8'h00);
        run(cyc);
        check("t3_latency", cyc, 289);
        check_full("t3");
        @(negedge clk);
        start = 1'b0;
`else
        // Early stop: plaintext 'a' then 8'h05
        pulse_reset();
        prep(8'h63, 8'h00);
        run(cyc);
        check("chk_latency", cyc, 19);
        check("chk_invalid", invalid, 1);
        check("chk_dec0", dmem[0], 8'h61);
        check("chk_dec1", dmem[1], 8'h05);
        check("chk_dec_writes", dec_wr_cnt, 2);
        check("chk_no_k2", k2_seen, 0);
        repeat (3) @(posedge clk);
        #1;
        check("chk_invalid_hold", invalid, 1);
        check("chk_dec_writes_hold", dec_wr_cnt, 2);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("chk_finish_drop", finish, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
